id_ex_reg: RTL and testbench



---
 rtl/id_ex_reg.sv | 106 ++++++++++
 tb/tb_id_ex_reg.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decode operands for execute, with flush > stall > load
// priority and write-back refresh of captured operands. Optional counters: IDEX_PERF_CNT_EN.
module id_ex_reg #(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [XLEN-1:0]   id_readdata1,
   input  logic [XLEN-1:0]   id_readdata2,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [4:0]        id_rs1,
   input  logic [4:0]        id_rs2,
   input  logic [4:0]        id_rd,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              wb_we,
   input  logic [4:0]        wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_readdata1,
   output logic [XLEN-1:0]   ex_readdata2,
   output logic [XLEN-1:0]   ex_imm,
   output logic [4:0]        ex_rs1,
   output logic [4:0]        ex_rs2,
   output logic [4:0]        ex_rd,
   output logic [CTRL_W-1:0] ex_ctrl
`ifdef IDEX_PERF_CNT_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       bubble_cnt
`endif
);

   // Stage control: flush inserts a bubble, stall holds the slot, otherwise the slot loads.
   // Register x0 is never a forwarding source, so wb_rd == 0 cannot refresh an operand.
   logic wb_live;
   logic ld_hit1, ld_hit2;
   logic st_hit1, st_hit2;

   assign wb_live = wb_we && (wb_rd != 5'd0);
   assign ld_hit1 = wb_live && (wb_rd == id_rs1);
   assign ld_hit2 = wb_live && (wb_rd == id_rs2);
   assign st_hit1 = wb_live && (wb_rd == ex_rs1);
   assign st_hit2 = wb_live && (wb_rd == ex_rs2);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ex_valid     <= 1'b0;
         ex_pc        <= '0;
         ex_readdata1 <= '0;
         ex_readdata2 <= '0;
         ex_imm       <= '0;
         ex_rs1       <= '0;
         ex_rs2       <= '0;
         ex_rd        <= '0;
         ex_ctrl      <= '0;
      end else if (flush) begin
         ex_valid     <= 1'b0;
         ex_pc        <= '0;
         ex_readdata1 <= '0;
         ex_readdata2 <= '0;
         ex_imm       <= '0;
         ex_rs1       <= '0;
         ex_rs2       <= '0;
         ex_rd        <= '0;
         ex_ctrl      <= '0;
      end else if (stall) begin
         // A held instruction keeps tracking write-backs to its source registers.
         if (st_hit1) ex_readdata1 <= wb_data;
         if (st_hit2) ex_readdata2 <= wb_data;
      end else begin
         ex_valid     <= id_valid;
         ex_pc        <= id_pc;
         ex_readdata1 <= ld_hit1 ? wb_data : id_readdata1;
         ex_readdata2 <= ld_hit2 ? wb_data : id_readdata2;
         ex_imm       <= id_imm;
         ex_rs1       <= id_rs1;
         ex_rs2       <= id_rs2;
         ex_rd        <= id_rd;
         ex_ctrl      <= id_ctrl;
      end
   end

`ifdef IDEX_PERF_CNT_EN
   logic bubble_edge;
   assign bubble_edge = flush || (!stall && !id_valid);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (stall && !flush && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
         if (bubble_edge && (bubble_cnt != 32'hFFFF_FFFF))
            bubble_cnt <= bubble_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: spec-level stage model compared every cycle,
// plus directed vectors with literal expectations.
module tb_id_ex_reg;
   localparam int XLEN   = 32;
   localparam int CTRL_W = 16;

   logic              clk, rstn, stall, flush, id_valid;
   logic [XLEN-1:0]   id_pc, id_readdata1, id_readdata2, id_imm;
   logic [4:0]        id_rs1, id_rs2, id_rd;
   logic [CTRL_W-1:0] id_ctrl;
   logic              wb_we;
   logic [4:0]        wb_rd;
   logic [XLEN-1:0]   wb_data;
   logic              ex_valid;
   logic [XLEN-1:0]   ex_pc, ex_readdata1, ex_readdata2, ex_imm;
   logic [4:0]        ex_rs1, ex_rs2, ex_rd;
   logic [CTRL_W-1:0] ex_ctrl;
`ifdef IDEX_PERF_CNT_EN
   logic [31:0]       stall_cnt, bubble_cnt;
   logic [31:0]       m_stall_cnt, m_bubble_cnt;
`endif

   id_ex_reg #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
      .clk(clk), .rstn(rstn), .stall(stall), .flush(flush), .id_valid(id_valid),
      .id_pc(id_pc), .id_readdata1(id_readdata1), .id_readdata2(id_readdata2),
      .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_ctrl(id_ctrl),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_readdata1(ex_readdata1),
      .ex_readdata2(ex_readdata2), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_rd(ex_rd), .ex_ctrl(ex_ctrl)
`ifdef IDEX_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard counters
   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model of the execute slot, kept as one record.
   typedef struct packed {
      logic              v;
      logic [XLEN-1:0]   pc, rd1, rd2, imm;
      logic [4:0]        rs1, rs2, rd;
      logic [CTRL_W-1:0] ctrl;
   } slot_t;
   slot_t m;

   // Value a reader of register rs would see given the write-back happening this edge.
   function automatic logic [XLEN-1:0] seen(input logic [4:0] rs, input logic [XLEN-1:0] d);
      if (wb_we && wb_rd != 5'd0 && wb_rd == rs) return wb_data;
      return d;
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m = '0;
`ifdef IDEX_PERF_CNT_EN
         m_stall_cnt  = 0;
         m_bubble_cnt = 0;
`endif
      end else begin
`ifdef IDEX_PERF_CNT_EN
         if (stall && !flush && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt = m_stall_cnt + 1;
         if ((flush || (!stall && !id_valid)) && m_bubble_cnt != 32'hFFFF_FFFF)
            m_bubble_cnt = m_bubble_cnt + 1;
`endif
         if (flush) m = '0;
         else if (stall) begin
            m.rd1 = seen(m.rs1, m.rd1);
            m.rd2 = seen(m.rs2, m.rd2);
         end else begin
            m = '{v: id_valid, pc: id_pc, rd1: seen(id_rs1, id_readdata1),
                  rd2: seen(id_rs2, id_readdata2), imm: id_imm, rs1: id_rs1,
                  rs2: id_rs2, rd: id_rd, ctrl: id_ctrl};
         end
      end
   end

   // compare process: every falling edge while enabled
   always @(negedge clk) begin
      if (chk_en) begin
         chk("ex_valid", 32'(ex_valid), 32'(m.v));
         chk("ex_pc", ex_pc, m.pc);
         chk("ex_readdata1", ex_readdata1, m.rd1);
         chk("ex_readdata2", ex_readdata2, m.rd2);
         chk("ex_imm", ex_imm, m.imm);
         chk("ex_rs1", 32'(ex_rs1), 32'(m.rs1));
         chk("ex_rs2", 32'(ex_rs2), 32'(m.rs2));
         chk("ex_rd", 32'(ex_rd), 32'(m.rd));
         chk("ex_ctrl", 32'(ex_ctrl), 32'(m.ctrl));
`ifdef IDEX_PERF_CNT_EN
         chk("stall_cnt", stall_cnt, m_stall_cnt);
         chk("bubble_cnt", bubble_cnt, m_bubble_cnt);
`endif
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] imm, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic [15:0] ctrl);
      id_valid = v; id_pc = pc; id_readdata1 = d1; id_readdata2 = d2; id_imm = imm;
      id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_ctrl = ctrl;
   endtask

   task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
      wb_we = we; wb_rd = rd; wb_data = d;
   endtask

   task automatic randomize_inputs();
      set_id(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom,
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
             16'($urandom));
      set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
   endtask

   initial begin
      rstn = 1'b0; stall = 1'b0; flush = 1'b0;
      set_id(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
      set_wb(1'b0, 0, 0);
      repeat (2) @(posedge clk);
      #2 rstn = 1'b1;
      chk_en = 1'b1;

      // async reset mid-cycle, with a held instruction in the slot
      randomize_inputs(); id_valid = 1'b1;
      tick();
      stall = 1'b1; randomize_inputs();
      tick();
      #1 rstn = 1'b0;
      #1;
      chk("rst_ex_valid", 32'(ex_valid), 32'd0);
      chk("rst_ex_pc", ex_pc, 32'd0);
      chk("rst_ex_readdata1", ex_readdata1, 32'd0);
      chk("rst_ex_ctrl", 32'(ex_ctrl), 32'd0);
      chk("rst_ex_rd", 32'(ex_rd), 32'd0);
      rstn = 1'b1;
      stall = 1'b0;

      // plain load
      set_wb(1'b0, 0, 0);
      set_id(1'b1, 32'h0000_3004, 32'h1111_1111, 32'h2222_2222, 32'hFFFF_FFF0,
             5'd5, 5'd7, 5'd3, 16'hABCD);
      tick();
      chk("load_ex_pc", ex_pc, 32'h0000_3004);
      chk("load_ex_readdata1", ex_readdata1, 32'h1111_1111);
      chk("load_ex_valid", 32'(ex_valid), 32'd1);

      // stall with refresh of rs2
      stall = 1'b1;
      set_id(1'b0, 32'h0BAD_0000, 32'h0BAD_0001, 32'h0BAD_0002, 32'h0, 5'd1, 5'd2, 5'd4, 16'h0);
      set_wb(1'b1, 5'd7, 32'hDEAD_BEEF);
      tick();
      chk("stall_ex_readdata2", ex_readdata2, 32'hDEAD_BEEF);
      chk("stall_ex_readdata1", ex_readdata1, 32'h1111_1111);
      chk("stall_ex_pc", ex_pc, 32'h0000_3004);
      chk("stall_ex_rd", 32'(ex_rd), 32'd3);
      chk("stall_ex_ctrl", 32'(ex_ctrl), 32'hABCD);
      // stall with wb_rd = 0 must not touch the operands
      set_wb(1'b1, 5'd0, 32'h7777_7777);
      tick();
      chk("stall_x0_readdata2", ex_readdata2, 32'hDEAD_BEEF);

      // load bypass, both operands
      stall = 1'b0;
      set_id(1'b1, 32'h0000_3008, 32'h0000_0001, 32'h0000_0002, 32'h10, 5'd9, 5'd9, 5'd9, 16'h0101);
      set_wb(1'b1, 5'd9, 32'h5A5A_5A5A);
      tick();
      chk("byp_ex_readdata1", ex_readdata1, 32'h5A5A_5A5A);
      chk("byp_ex_readdata2", ex_readdata2, 32'h5A5A_5A5A);
      // x0 never bypasses
      set_id(1'b1, 32'h0000_300C, 32'h0000_0033, 32'h0000_0044, 32'h0, 5'd0, 5'd9, 5'd2, 16'h0202);
      set_wb(1'b1, 5'd0, 32'h5A5A_5A5A);
      tick();
      chk("x0_ex_readdata1", ex_readdata1, 32'h0000_0033);
      chk("x0_ex_readdata2", ex_readdata2, 32'h0000_0044);
      // write enable low never bypasses
      set_id(1'b1, 32'h0000_3010, 32'h0000_0055, 32'h0000_0066, 32'h0, 5'd4, 5'd4, 5'd2, 16'h0303);
      set_wb(1'b0, 5'd4, 32'h9999_9999);
      tick();
      chk("nowe_ex_readdata1", ex_readdata1, 32'h0000_0055);

      // flush beats stall
      stall = 1'b1; flush = 1'b1;
      tick();
      chk("flush_ex_valid", 32'(ex_valid), 32'd0);
      chk("flush_ex_ctrl", 32'(ex_ctrl), 32'd0);
      chk("flush_ex_rd", 32'(ex_rd), 32'd0);
      chk("flush_ex_pc", ex_pc, 32'd0);
      stall = 1'b0; flush = 1'b0;

`ifdef IDEX_PERF_CNT_EN
      // counters: 3 stalls, 2 flushes, 1 invalid load from a fresh reset
      #1 rstn = 1'b0;
      #1 rstn = 1'b1;
      set_wb(1'b0, 0, 0);
      set_id(1'b1, 32'h40, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 16'h1);
      stall = 1'b1;
      repeat (3) tick();
      stall = 1'b0; flush = 1'b1;
      repeat (2) tick();
      flush = 1'b0; id_valid = 1'b0;
      tick();
      chk("cnt_stall", stall_cnt, 32'd3);
      chk("cnt_bubble", bubble_cnt, 32'd3);
`endif

      // random traffic checked by the model
      for (int i = 0; i < 300; i++) begin
         randomize_inputs();
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 7) == 0);
         tick();
      end

      @(negedge clk);
      #1 chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, n_cmp=%0d", n_cmp);
      $fatal(1);
   end
endmodule
